// File: rtl/wb_dma.sv
// Single-channel Wishbone DMA: register slave port plus a word-copy master.
// One outstanding master request; NEXT drops cyc for a cycle between words.
`timescale 1ns/1ps
module wb_dma (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc,
  input  logic        wbs_stb,
  input  logic        wbs_we,
  input  logic [31:0] wbs_adr,
  input  logic [3:0]  wbs_sel,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack,
  output logic        wbs_stall,
  output logic        wbm_cyc,
  output logic        wbm_stb,
  output logic        wbm_we,
  output logic [31:0] wbm_adr,
  output logic [3:0]  wbm_sel,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack,
  input  logic        wbm_err,
  input  logic        wbm_stall,
  output logic        irq
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT
  } state_t;

  state_t      state;
  logic [29:0] src;
  logic [29:0] dst;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        error;
  logic        req;
  logic        wr;
  logic        start;
  logic [31:0] rdata;
  logic        unused;

  assign wbs_stall = 1'b0;
  assign wbm_sel   = 4'hF;

  // A held strobe is one request: the ack cycle itself is not a new one.
  assign req   = wbs_cyc & wbs_stb & ~wbs_ack;
  assign wr    = req & wbs_we & ~busy;
  assign start = wr & (wbs_adr[3:2] == 2'd3) & wbs_dat_i[0];

  assign unused = ^{wbs_sel, wbs_adr[31:4], wbs_adr[1:0]};

  always_comb begin
    rdata = 32'h0;
    unique case (wbs_adr[3:2])
      2'd0: rdata = {src, 2'b00};
      2'd1: rdata = {dst, 2'b00};
      2'd2: rdata = {16'h0, len};
      2'd3: rdata = {29'h0, error, done, busy};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      len       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      wbs_ack   <= 1'b0;
      wbs_dat_o <= '0;
      wbm_cyc   <= 1'b0;
      wbm_stb   <= 1'b0;
      wbm_we    <= 1'b0;
      wbm_adr   <= '0;
      wbm_dat_o <= '0;
      irq       <= 1'b0;
    end else begin
      wbs_ack <= req;
      irq     <= 1'b0;
      if (req & ~wbs_we)
        wbs_dat_o <= rdata;
      if (wr) begin
        case (wbs_adr[3:2])
          2'd0:    src <= wbs_dat_i[31:2];
          2'd1:    dst <= wbs_dat_i[31:2];
          2'd2:    len <= wbs_dat_i[15:0];
          default: ;
        endcase
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            done  <= 1'b0;
            error <= 1'b0;
            if (len == 16'd0) begin
              done <= 1'b1;
              irq  <= 1'b1;
            end else begin
              busy    <= 1'b1;
              state   <= RD_REQ;
              wbm_cyc <= 1'b1;
              wbm_stb <= 1'b1;
              wbm_we  <= 1'b0;
              wbm_adr <= {src, 2'b00};
            end
          end
        end
        RD_REQ: begin
          if (!wbm_stall) begin
            wbm_stb <= 1'b0;
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (wbm_err) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            irq     <= 1'b1;
            wbm_cyc <= 1'b0;
            state   <= IDLE;
          end else if (wbm_ack) begin
            wbm_dat_o <= wbm_dat_i;
            wbm_stb   <= 1'b1;
            wbm_we    <= 1'b1;
            wbm_adr   <= {dst, 2'b00};
            state     <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (!wbm_stall) begin
            wbm_stb <= 1'b0;
            state   <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (wbm_err) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            irq     <= 1'b1;
            wbm_cyc <= 1'b0;
            wbm_we  <= 1'b0;
            state   <= IDLE;
          end else if (wbm_ack) begin
            src     <= src + 30'd1;
            dst     <= dst + 30'd1;
            len     <= len - 16'd1;
            wbm_cyc <= 1'b0;
            wbm_we  <= 1'b0;
            if (len == 16'd1) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              irq   <= 1'b1;
              state <= IDLE;
            end else begin
              state <= NEXT;
            end
          end
        end
        NEXT: begin
          wbm_cyc <= 1'b1;
          wbm_stb <= 1'b1;
          wbm_adr <= {src, 2'b00};
          state   <= RD_REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dma.sv
// Bench for wb_dma: register table, directed transfers, random transfers
// checked against a word-copy memory model, and a mid-transfer reset.
`timescale 1ns/1ps
module tb_wb_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_cyc = 1'b0;
  logic        s_stb = 1'b0;
  logic        s_we = 1'b0;
  logic [31:0] s_adr = '0;
  logic [3:0]  s_sel = '0;
  logic [31:0] s_dat = '0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack;
  logic        wbs_stall;
  logic        wbm_cyc;
  logic        wbm_stb;
  logic        wbm_we;
  logic [31:0] wbm_adr;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_dat_o;
  logic [31:0] m_dat = '0;
  logic        m_ack = 1'b0;
  logic        m_err = 1'b0;
  logic        m_stall = 1'b0;
  logic        irq;

  always #5 clk = ~clk;

  wb_dma dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wbs_cyc   (s_cyc),
    .wbs_stb   (s_stb),
    .wbs_we    (s_we),
    .wbs_adr   (s_adr),
    .wbs_sel   (s_sel),
    .wbs_dat_i (s_dat),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack   (wbs_ack),
    .wbs_stall (wbs_stall),
    .wbm_cyc   (wbm_cyc),
    .wbm_stb   (wbm_stb),
    .wbm_we    (wbm_we),
    .wbm_adr   (wbm_adr),
    .wbm_sel   (wbm_sel),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (m_dat),
    .wbm_ack   (m_ack),
    .wbm_err   (m_err),
    .wbm_stall (m_stall),
    .irq       (irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } req_t;

  req_t        logq[$];
  logic [31:0] mem [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];

  int stall_n = 0;
  int ack_dly = 0;
  int err_at = -1;
  int req_cnt = 0;
  int irq_cnt = 0;
  int cyc_cnt = 0;
  int gap_n = 0;
  int gap_sum = 0;
  int proto_bad = 0;
  logic irq_ack = 1'b0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_96E1;
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : pat(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  // Memory-side responder: stalls, delayed ack, error injection, logging.
  initial begin : resp
    bit          pend;
    bit          p_we;
    bit          p_err;
    bit          seen;
    logic [31:0] p_adr;
    logic [31:0] p_dat;
    int          dly;
    int          scnt;
    int          low;
    pend = 0; seen = 0; dly = 0; scnt = 0; low = 0;
    p_we = 0; p_err = 0; p_adr = '0; p_dat = '0;
    forever begin
      @(negedge clk);
      m_ack = 1'b0;
      m_err = 1'b0;
      m_stall = 1'b0;
      m_dat = $urandom;
      if (!rst_n) begin
        pend = 0; scnt = 0; seen = 0; low = 0;
      end else begin
        if (irq) begin
          irq_cnt++;
          seen = 0;
          low = 0;
        end
        if (wbm_cyc) begin
          cyc_cnt++;
          if (seen && low > 0) begin
            gap_n++;
            gap_sum += low;
          end
          low = 0;
          seen = 1;
        end else if (seen) begin
          low++;
        end
        if (pend) begin
          if (wbm_cyc && wbm_stb) proto_bad++;
          if (dly > 0) dly--;
          else begin
            pend = 0;
            if (p_err) m_err = 1'b1;
            else begin
              m_ack = 1'b1;
              if (p_we) mem[p_adr] = p_dat;
              else m_dat = rd_mem(p_adr);
            end
          end
        end else if (wbm_cyc && wbm_stb) begin
          if (scnt < stall_n) begin
            m_stall = 1'b1;
            scnt++;
          end else begin
            scnt = 0;
            pend = 1;
            dly = ack_dly;
            p_we = wbm_we;
            p_adr = wbm_adr;
            p_dat = wbm_dat_o;
            p_err = (req_cnt == err_at);
            req_cnt++;
            if (wbm_sel !== 4'hF || wbm_adr[1:0] !== 2'b00) proto_bad++;
            logq.push_back('{wbm_we, wbm_adr, wbm_dat_o});
          end
        end
      end
    end
  end

  task automatic bus(input bit we, input logic [3:0] a,
                     input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    s_cyc = 1'b1;
    s_stb = 1'b1;
    s_we = we;
    s_adr = $urandom;
    s_adr[3:2] = a[3:2];
    s_sel = 4'($urandom);
    s_dat = wd;
    @(negedge clk);
    check("ack", 32'(wbs_ack), 32'd1);
    rd = wbs_dat_o;
    irq_ack = irq;
    s_cyc = 1'b0;
    s_stb = 1'b0;
    @(negedge clk);
    check("ack_single", 32'(wbs_ack), 32'd0);
  endtask

  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst,
                          input int len, input int sn, input int ad,
                          input int err_rel, input bit poll,
                          input bit meddle);
    int          base;
    int          i0;
    int          g0;
    int          s0;
    int          c0;
    int          n_req;
    int          adv;
    int          k;
    logic [31:0] d;
    logic [31:0] v;
    logic [15:0] lens[$];
    req_t        e;
    stall_n = sn;
    ack_dly = ad;
    err_at = (err_rel < 0) ? -1 : req_cnt + err_rel;
    base = logq.size();
    i0 = irq_cnt; g0 = gap_n; s0 = gap_sum; c0 = cyc_cnt;
    bus(1, 4'd0, src, v);
    bus(1, 4'd4, dst, v);
    bus(1, 4'd8, 32'(len), v);
    bus(1, 4'd12, 32'd1, v);
    check("irq_at_start", 32'(irq_ack), 32'(len == 0));
    if (meddle) begin
      bus(1, 4'd0, 32'h0, v);
      bus(1, 4'd4, 32'h10, v);
      bus(1, 4'd8, 32'd9, v);
      bus(1, 4'd12, 32'd1, v);
    end
    k = 0;
    do begin
      if (poll) begin
        bus(0, 4'd8, 32'h0, v);
        if (lens.size() == 0 || lens[$] != v[15:0]) lens.push_back(v[15:0]);
      end
      bus(0, 4'd12, 32'h0, v);
      k++;
    end while (v[0] && k < 400);
    check("idle_timeout", 32'(v[0]), 32'd0);
    if (poll) begin
      bus(0, 4'd8, 32'h0, v);
      if (lens[$] != v[15:0]) lens.push_back(v[15:0]);
      check("len_steps", 32'(lens.size()), 32'(len + 1));
      for (int j = 0; j < lens.size() && j <= len; j++)
        check("len_step", 32'(lens[j]), 32'(len - j));
    end
    n_req = (err_rel >= 0) ? err_rel + 1 : 2 * len;
    adv = (err_rel >= 0) ? err_rel / 2 : len;
    check("req_count", 32'(logq.size() - base), 32'(n_req));
    d = '0;
    for (int r = 0; r < n_req; r++) begin
      logic [31:0] sa;
      logic [31:0] da;
      sa = src + 32'(4 * (r / 2));
      da = dst + 32'(4 * (r / 2));
      if (r % 2 == 0) d = ref_rd(sa);
      else if (r != err_rel) ref_mem[da] = d;
      if (base + r < logq.size()) begin
        e = logq[base + r];
        check("req_we", 32'(e.we), 32'(r % 2));
        check("req_adr", e.adr, (r % 2 == 0) ? sa : da);
        if (r % 2 == 1) check("req_dat", e.dat, d);
      end
    end
    bus(0, 4'd0, 32'h0, v);
    check("src_rb", v, src + 32'(4 * adv));
    bus(0, 4'd4, 32'h0, v);
    check("dst_rb", v, dst + 32'(4 * adv));
    bus(0, 4'd8, 32'h0, v);
    check("len_rb", v, 32'(len - adv));
    bus(0, 4'd12, 32'h0, v);
    check("status", v, (err_rel >= 0 && len > 0) ? 32'h4 : 32'h2);
    check("irq_pulses", 32'(irq_cnt - i0), 32'd1);
    if (len == 0) check("no_cyc", 32'(cyc_cnt - c0), 32'd0);
    if (err_rel < 0 && len > 0) begin
      check("gap_count", 32'(gap_n - g0), 32'(len - 1));
      check("gap_cycles", 32'(gap_sum - s0), 32'(len - 1));
    end
    for (int i = 0; i < adv; i++)
      check("mem", rd_mem(dst + 32'(4 * i)), ref_rd(dst + 32'(4 * i)));
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  r;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin : main
    logic [31:0] v;
    int          base;
    int          c0;
    int          k;
    tbl[0]  = '{1'b0, 2'd0, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, 2'd1, 32'h0,        32'h0};
    tbl[2]  = '{1'b0, 2'd2, 32'h0,        32'h0};
    tbl[3]  = '{1'b0, 2'd3, 32'h0,        32'h0};
    tbl[4]  = '{1'b1, 2'd0, 32'h12345677, 32'h0};
    tbl[5]  = '{1'b0, 2'd0, 32'h0,        32'h12345674};
    tbl[6]  = '{1'b1, 2'd1, 32'hFFFFFFFF, 32'h0};
    tbl[7]  = '{1'b0, 2'd1, 32'h0,        32'hFFFFFFFC};
    tbl[8]  = '{1'b1, 2'd2, 32'hABCD1234, 32'h0};
    tbl[9]  = '{1'b0, 2'd2, 32'h0,        32'h00001234};
    tbl[10] = '{1'b1, 2'd3, 32'hFFFFFFFE, 32'h0};
    tbl[11] = '{1'b0, 2'd3, 32'h0,        32'h0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cyc", 32'(wbm_cyc), 32'd0);
    check("rst_stb", 32'(wbm_stb), 32'd0);
    check("rst_we", 32'(wbm_we), 32'd0);
    check("rst_adr", wbm_adr, 32'h0);
    check("rst_mdat", wbm_dat_o, 32'h0);
    check("rst_sel", 32'(wbm_sel), 32'hF);
    check("rst_ack", 32'(wbs_ack), 32'd0);
    check("rst_sdat", wbs_dat_o, 32'h0);
    check("rst_irq", 32'(irq), 32'd0);
    check("stall_tie", 32'(wbs_stall), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      bus(tbl[i].we, {tbl[i].r, 2'b00}, tbl[i].wd, v);
      if (!tbl[i].we) check($sformatf("tbl%0d", i), v, tbl[i].exp);
    end

    run_xfer(32'h100, 32'h200, 3, 0, 0, -1, 1'b0, 1'b0);
    run_xfer(32'h100, 32'h200, 3, 2, 3, -1, 1'b1, 1'b0);
    run_xfer(32'h400, 32'h500, 4, 0, 0, 2, 1'b0, 1'b0);
    run_xfer(32'h600, 32'h700, 0, 0, 0, -1, 1'b0, 1'b0);
    run_xfer(32'hFFFFFFFC, 32'h300, 2, 2, 3, -1, 1'b0, 1'b1);

    for (int t = 0; t < 20; t++) begin
      logic [31:0] s;
      logic [31:0] d;
      int          l;
      int          er;
      s = $urandom & 32'hFFFF_FFFC;
      if (t % 5 == 0) s = 32'hFFFF_FFF4;
      d = $urandom & 32'hFFFF_FFFC;
      l = int'($urandom_range(0, 5));
      er = -1;
      if (l > 0 && $urandom_range(0, 3) == 0)
        er = int'($urandom_range(0, 2 * l - 1));
      run_xfer(s, d, l, int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), er, 1'b0, 1'b0);
    end

    // Reset while a write is waiting for its ack.
    stall_n = 0;
    ack_dly = 6;
    err_at = -1;
    base = logq.size();
    bus(1, 4'd0, 32'h800, v);
    bus(1, 4'd4, 32'h900, v);
    bus(1, 4'd8, 32'd4, v);
    bus(1, 4'd12, 32'd1, v);
    k = 0;
    while (logq.size() < base + 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("wr_issued", 32'(logq.size() >= base + 2), 32'd1);
    @(negedge clk);
    check("pre_rst_cyc", 32'(wbm_cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_cyc", 32'(wbm_cyc), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      bus(0, 4'(r * 4), 32'h0, v);
      check($sformatf("rst_reg%0d", r), v, 32'h0);
    end
    c0 = cyc_cnt;
    base = logq.size();
    repeat (20) @(negedge clk);
    check("post_rst_cyc", 32'(cyc_cnt - c0), 32'd0);
    check("post_rst_req", 32'(logq.size() - base), 32'd0);
    check("protocol", 32'(proto_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_dma.md
WB_DMA -- requirements
Module: wb_dma

Interface
REQ-001 SHALL have no parameters; bus width fixed at 32 data / 32 address, 4 byte selects.
REQ-002 SHALL use one clock and an asynchronous active-low reset: clk  in  1  system clock; rst_n  in  1  async active-low reset.
REQ-003 wbs_cyc  in  1  slave-port cycle.
REQ-004 wbs_stb  in  1  slave-port strobe.
REQ-005 wbs_we  in  1  slave-port write enable.
REQ-006 wbs_adr  in  32  slave-port byte address; only bits [3:2] decoded.
REQ-007 wbs_sel  in  4  slave-port byte selects; ignored, full-word access only.
REQ-008 wbs_dat_i  in  32  slave-port write data.
REQ-009 wbs_dat_o  out  32  slave-port read data.
REQ-010 wbs_ack  out  1  slave-port acknowledge.
REQ-011 wbs_stall  out  1  slave-port stall; tied 0.
REQ-012 wbm_cyc, wbm_stb, wbm_we  out  1 each  master-port cycle, strobe, write enable.
REQ-013 wbm_adr  out  32  master-port byte address, bits [1:0] always 0.
REQ-014 wbm_sel  out  4  master-port byte selects, always 4'hF.
REQ-015 wbm_dat_o  out  32  master-port write data.
REQ-016 wbm_dat_i  in  32  master-port read data.
REQ-017 wbm_ack, wbm_err, wbm_stall  in  1 each  master-port acknowledge, error, stall.
REQ-018 irq  out  1  one-cycle pulse when a transfer ends (done or error).

Function
REQ-019 Register map (adr[3:2]): 0 SRC, 1 DST, 2 LEN (bits [15:0], word count), 3 CTRL/STATUS.
REQ-020 STATUS read: bit0 busy, bit1 done, bit2 error, other bits 0.
REQ-021 CTRL write: bit0=1 starts a transfer; other bits ignored.
REQ-022 Slave: wbs_ack asserted exactly 1 cycle after each cycle with wbs_cyc&wbs_stb; ack is never asserted for two cycles per request.
REQ-023 SRC/DST store bits [31:2]; bits [1:0] read 0.
REQ-024 While busy, writes to SRC/DST/LEN/CTRL are acked and have no effect.
REQ-025 While busy, SRC/DST read the current pointers and LEN reads the remaining word count.
REQ-026 Start clears done and error, and sets busy next cycle.
REQ-027 Start with LEN=0: no master activity; busy stays 0; done=1 and irq pulses 1 cycle after the start write is accepted.
REQ-028 Master FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT.
REQ-029 IDLE: cyc=stb=0; on start with LEN!=0 go to RD_REQ.
REQ-030 RD_REQ: cyc=stb=1, we=0, adr=SRC; go to RD_WAIT when wbm_stall=0.
REQ-031 RD_WAIT: cyc=1, stb=0; on ack, latch wbm_dat_i into a data buffer and go to WR_REQ.
REQ-032 WR_REQ: cyc=stb=1, we=1, adr=DST, dat_o=buffer; go to WR_WAIT when wbm_stall=0.
REQ-033 WR_WAIT: cyc=1, stb=0; on ack, SRC+=4, DST+=4, LEN-=1; then go to IDLE with done=1 if the new LEN is 0, else go to NEXT.
REQ-034 NEXT: cyc=0 for exactly one cycle to release the shared bus, then go to RD_REQ.
REQ-035 wbm_err in RD_WAIT or WR_WAIT: error=1, go to IDLE with cyc=0 next cycle, irq pulse; pointers and LEN are not advanced.
REQ-036 ack and err in the same cycle: treated as err.
REQ-037 wbm_ack/wbm_err outside RD_WAIT/WR_WAIT are ignored.
REQ-038 Pointer arithmetic is modulo 2^32 (0xFFFFFFFC+4 wraps to 0); LEN is 16-bit and never underflows.
REQ-039 Only one outstanding master request at any time.

Reset
REQ-040 rst_n low asynchronously forces: FSM=IDLE; wbm_cyc=wbm_stb=wbm_we=0; wbm_adr=0; wbm_dat_o=0; wbm_sel=4'hF; wbs_ack=0; wbs_dat_o=0; irq=0; SRC=DST=LEN=0; busy=done=error=0.
REQ-041 Reset asserted mid-transfer aborts the transfer immediately; no further bus cycles occur after rst_n returns high.

Verification
REQ-042 SRC=0x100, DST=0x200, LEN=3, start, memory model with 0 waits -> 3 reads at 0x100/104/108 and 3 writes at 0x200/204/208 with matching data; cyc low exactly 1 cycle between words; STATUS=0x2; one irq pulse.
REQ-043 Same transfer with wbm_stall high 2 cycles on each request and ack delayed 3 cycles -> stb held until stall drops; data correct; LEN reads 2,1,0 during progress.
REQ-044 wbm_err on the second read of LEN=4 -> STATUS=0x4; SRC=base+4; LEN=3; no write issued for word 2; irq pulse.
REQ-045 LEN=0 start -> no wbm_cyc; done=1 next cycle; irq pulse.
REQ-046 Write SRC=0x0 and start again while busy -> ignored, transfer completes unchanged; SRC=0xFFFFFFFC, LEN=2 -> second read at 0x00000000.
REQ-047 rst_n pulsed low during WR_WAIT -> wbm_cyc drops in the same cycle; all registers read 0; bus idle afterwards.
